// File: rtl/clock_pkg.sv
// Shared types and constants for the clock_checker block.
package clock_pkg;

   typedef enum logic [1:0] {IDLE, SYNC, HIGH, LOW} state_e;

   localparam int CNT_W_DEF = 8;
   localparam int ERRC_W    = 8;

endpackage

// File: rtl/clock_checker_edge_detect.sv
// Single-register edge detector; the input is synchronous to clk_in.
module edge_detect (
   input  logic clk_in,
   input  logic rst,
   input  logic sig_in,
   output logic rise,
   output logic fall
);

   logic sig_q;

   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) sig_q <= 1'b0;
      else      sig_q <= sig_in;
   end

   assign rise = sig_in & ~sig_q;
   assign fall = ~sig_in & sig_q;

endmodule

// File: rtl/clock_checker.sv
// Measures period and high time of clk_mon in clk_in cycles, tracks lock and errors.
// Optional duty-cycle check enabled by defining CLK_CHECK_DUTY_EN.
module clock_checker
   import clock_pkg::*;
#(
   parameter int DIV    = 4,
   parameter int CNT_W  = CNT_W_DEF,
   parameter int LOCK_N = 4,
   parameter int TOL    = 0
) (
   input  logic              clk_in,
   input  logic              rst,
   input  logic              clk_mon,
   output logic [CNT_W-1:0]  period,
   output logic [CNT_W-1:0]  high_time,
   output logic              meas_valid,
   output logic              locked,
   output logic              err,
   output logic [ERRC_W-1:0] err_count
);

   localparam int               GR_W    = $clog2(LOCK_N + 1);
   localparam logic [GR_W-1:0]  LOCK_V  = GR_W'(LOCK_N);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_e              state_q;
   logic [CNT_W-1:0]    cnt_q, period_q, high_time_q;
   logic                mv_q, locked_q, err_q;
   logic [ERRC_W-1:0]   errc_q;
   logic [GR_W-1:0]     good_run_q, good_run_d;
   logic                rise, fall;
   logic                done, tout, bad, rep, in_tol, duty_ok;
   int                  dev;
`ifdef CLK_CHECK_DUTY_EN
   int                  duty_dev;
`endif

   edge_detect u_mon_edge (
      .clk_in (clk_in),
      .rst    (rst),
      .sig_in (clk_mon),
      .rise   (rise),
      .fall   (fall)
   );

   always_comb begin
      dev    = int'(cnt_q) - DIV;
      in_tol = (dev <= TOL) && (dev >= -TOL);
`ifdef CLK_CHECK_DUTY_EN
      duty_dev = 2 * int'(high_time_q) - int'(cnt_q);
      duty_ok  = (duty_dev <= 1) && (duty_dev >= -1);
`else
      duty_ok  = 1'b1;
`endif
      done = rise && (state_q == HIGH || state_q == LOW);
      tout = !rise && (cnt_q == CNT_MAX) && (state_q != IDLE);
      // A rise while still HIGH means the fall was missed: always bad.
      bad  = tout || (done && (state_q == HIGH || !in_tol || !duty_ok));
      rep  = done || tout;
      if (bad)                            good_run_d = '0;
      else if (rep && good_run_q != LOCK_V) good_run_d = good_run_q + 1'b1;
      else                                good_run_d = good_run_q;
   end

   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         period_q    <= '0;
         high_time_q <= '0;
         mv_q        <= 1'b0;
         locked_q    <= 1'b0;
         err_q       <= 1'b0;
         errc_q      <= '0;
         good_run_q  <= '0;
      end else begin
         mv_q <= rep;
         if (rep) begin
            period_q   <= tout ? CNT_MAX : cnt_q;
            good_run_q <= good_run_d;
            locked_q   <= (good_run_d == LOCK_V);
            if (bad) begin
               err_q <= 1'b1;
               if (errc_q != '1) errc_q <= errc_q + 1'b1;
            end
         end
         case (state_q)
            IDLE: begin
               state_q <= SYNC;
               cnt_q   <= '0;
            end
            SYNC: begin
               if (rise) begin
                  state_q <= HIGH;
                  cnt_q   <= CNT_W'(1);
               end else if (tout) cnt_q <= '0;
               else               cnt_q <= cnt_q + 1'b1;
            end
            HIGH: begin
               if (rise) cnt_q <= CNT_W'(1);
               else if (tout) begin
                  state_q <= SYNC;
                  cnt_q   <= '0;
               end else begin
                  if (fall) begin
                     high_time_q <= cnt_q;
                     state_q     <= LOW;
                  end
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            LOW: begin
               if (rise) begin
                  state_q <= HIGH;
                  cnt_q   <= CNT_W'(1);
               end else if (tout) begin
                  state_q <= SYNC;
                  cnt_q   <= '0;
               end else cnt_q <= cnt_q + 1'b1;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign period     = period_q;
   assign high_time  = high_time_q;
   assign meas_valid = mv_q;
   assign locked     = locked_q;
   assign err        = err_q;
   assign err_count  = errc_q;

endmodule
